// File: rtl/pinpad_pkg.sv
// Shared types and key-code constants for the PIN-entry controller.
package pinpad_pkg;

  typedef logic [3:0] digit_t;

  localparam digit_t KEY_A    = 4'd10;
  localparam digit_t KEY_B    = 4'd11;
  localparam digit_t KEY_C    = 4'd12;
  localparam digit_t KEY_D    = 4'd13;
  localparam digit_t KEY_NONE = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHECK,
    ST_LOCKOUT
  } pin_state_t;

  function automatic logic is_digit(input digit_t code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/pinpad_key_debounce.sv
// Turns the scanner's level valid/code into one strobe per press; re-arms only
// after the key has been released for DEBOUNCE_CYCLES consecutive cycles.
module pinpad_key_debounce
  import pinpad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   key_valid,
  input  digit_t key_code,
  output logic   key_strobe,
  output digit_t strobe_code
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] stable_cnt_reg, stable_cnt_next;
  logic [CNT_W-1:0] release_cnt_reg, release_cnt_next;
  digit_t           prev_code_reg;
  logic             armed_reg, armed_next;
  logic             strobe_reg;
  digit_t           code_reg;
  logic             pressed;
  logic             fire;

  assign pressed = key_valid && (key_code != KEY_NONE);

  always_comb begin
    stable_cnt_next = '0;
    // The first pressed cycle already counts, so a steady press strobes on cycle DEBOUNCE_CYCLES.
    if (pressed) begin
      if ((stable_cnt_reg == '0) || (key_code != prev_code_reg)) begin
        stable_cnt_next = CNT_W'(1);
      end else if (stable_cnt_reg != CNT_MAX) begin
        stable_cnt_next = stable_cnt_reg + CNT_W'(1);
      end else begin
        stable_cnt_next = CNT_MAX;
      end
    end

    release_cnt_next = '0;
    if (!armed_reg && !key_valid) begin
      release_cnt_next = (release_cnt_reg == CNT_MAX) ? CNT_MAX
                                                      : release_cnt_reg + CNT_W'(1);
    end

    fire = armed_reg && (stable_cnt_next == CNT_MAX);

    armed_next = armed_reg;
    if (fire) begin
      armed_next = 1'b0;
    end else if (!armed_reg && (release_cnt_next == CNT_MAX)) begin
      armed_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stable_cnt_reg  <= '0;
      release_cnt_reg <= '0;
      prev_code_reg   <= KEY_NONE;
      armed_reg       <= 1'b1;
      strobe_reg      <= 1'b0;
      code_reg        <= KEY_NONE;
    end else begin
      stable_cnt_reg  <= stable_cnt_next;
      release_cnt_reg <= release_cnt_next;
      prev_code_reg   <= key_code;
      armed_reg       <= armed_next;
      strobe_reg      <= fire;
      code_reg        <= key_code;
    end
  end

  assign key_strobe  = strobe_reg;
  assign strobe_code = code_reg;

endmodule

// File: rtl/pinpad_entry_ctrl.sv
// PIN-entry sequencer: debounced keys drive a start/digit/backspace/cancel/submit FSM.
// Lockout after MAX_TRIES consecutive failures is built only with PINPAD_LOCKOUT_EN.
module pinpad_entry_ctrl
  import pinpad_pkg::*;
#(
  parameter int unsigned PIN_LEN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned MAX_TRIES       = 3,
  parameter int unsigned LOCKOUT_CYCLES  = 1000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         key_valid,
  input  logic [3:0]                   key_code,
  input  logic [4*PIN_LEN-1:0]         pin_ref,
  output logic                         entry_active,
  output logic [$clog2(PIN_LEN+1)-1:0] digit_count,
  output logic                         granted,
  output logic                         denied,
  output logic                         locked_out
);

  localparam int unsigned CNT_W = $clog2(PIN_LEN + 1);
  localparam int unsigned BUF_W = 4 * PIN_LEN;

  // Configurations outside these ranges are not supported.
  if (PIN_LEN < 1 || PIN_LEN > 8 || DEBOUNCE_CYCLES < 1 ||
      MAX_TRIES < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_params
  end

  logic   key_strobe;
  digit_t key_sc;

  pinpad_key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk         (clk),
    .reset_n     (reset_n),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_strobe  (key_strobe),
    .strobe_code (key_sc)
  );

  pin_state_t       state_reg;
  logic [BUF_W-1:0] pin_buf_reg;
  logic [CNT_W-1:0] digit_count_reg;
  logic             entry_active_reg;
  logic             granted_reg;
  logic             denied_reg;

  logic [BUF_W-1:0] buf_shl;
  logic [BUF_W-1:0] buf_shr;
  logic             buf_full;
  logic [PIN_LEN-1:0] nib_eq;
  logic             pin_match;

  assign buf_shl  = (pin_buf_reg << 4) | BUF_W'(key_sc);
  assign buf_shr  = pin_buf_reg >> 4;
  assign buf_full = (digit_count_reg == CNT_W'(PIN_LEN));

  for (genvar gi = 0; gi < PIN_LEN; gi++) begin : g_cmp
    assign nib_eq[gi] = (pin_buf_reg[gi*4 +: 4] == pin_ref[gi*4 +: 4]);
  end

  // A short entry leaves leading zero nibbles, so the count must also match.
  assign pin_match = buf_full && (&nib_eq);

`ifdef PINPAD_LOCKOUT_EN
  localparam int unsigned FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int unsigned LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  logic [FAIL_W-1:0] fail_cnt_reg;
  logic [FAIL_W-1:0] fail_cnt_inc;
  logic [LOCK_W-1:0] lock_timer_reg;
  logic              locked_out_reg;

  assign fail_cnt_inc = (fail_cnt_reg == FAIL_W'(MAX_TRIES)) ? fail_cnt_reg
                                                             : fail_cnt_reg + FAIL_W'(1);
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg        <= ST_IDLE;
      pin_buf_reg      <= '0;
      digit_count_reg  <= '0;
      entry_active_reg <= 1'b0;
      granted_reg      <= 1'b0;
      denied_reg       <= 1'b0;
`ifdef PINPAD_LOCKOUT_EN
      fail_cnt_reg     <= '0;
      lock_timer_reg   <= '0;
      locked_out_reg   <= 1'b0;
`endif
    end else begin
      granted_reg <= 1'b0;
      denied_reg  <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (key_strobe && (key_sc == KEY_A)) begin
            pin_buf_reg      <= '0;
            digit_count_reg  <= '0;
            state_reg        <= ST_ENTRY;
            entry_active_reg <= 1'b1;
          end
        end

        ST_ENTRY: begin
          if (key_strobe) begin
            if (is_digit(key_sc)) begin
              if (!buf_full) begin
                pin_buf_reg     <= buf_shl;
                digit_count_reg <= digit_count_reg + CNT_W'(1);
              end
            end else begin
              case (key_sc)
                KEY_A: begin
                  pin_buf_reg     <= '0;
                  digit_count_reg <= '0;
                end
                KEY_B: begin
                  if (digit_count_reg != '0) begin
                    pin_buf_reg     <= buf_shr;
                    digit_count_reg <= digit_count_reg - CNT_W'(1);
                  end
                end
                KEY_C: begin
                  pin_buf_reg      <= '0;
                  digit_count_reg  <= '0;
                  state_reg        <= ST_IDLE;
                  entry_active_reg <= 1'b0;
                end
                KEY_D: begin
                  state_reg        <= ST_CHECK;
                  entry_active_reg <= 1'b0;
                end
                default: ;
              endcase
            end
          end
        end

        ST_CHECK: begin
          pin_buf_reg     <= '0;
          digit_count_reg <= '0;
          state_reg       <= ST_IDLE;
          if (pin_match) begin
            granted_reg <= 1'b1;
`ifdef PINPAD_LOCKOUT_EN
            fail_cnt_reg <= '0;
`endif
          end else begin
            denied_reg <= 1'b1;
`ifdef PINPAD_LOCKOUT_EN
            fail_cnt_reg <= fail_cnt_inc;
            if (fail_cnt_inc == FAIL_W'(MAX_TRIES)) begin
              state_reg      <= ST_LOCKOUT;
              locked_out_reg <= 1'b1;
              lock_timer_reg <= LOCK_W'(LOCKOUT_CYCLES - 1);
            end
`endif
          end
        end

        ST_LOCKOUT: begin
`ifdef PINPAD_LOCKOUT_EN
          // Timer holds remaining cycles minus one, giving exactly LOCKOUT_CYCLES high cycles.
          if (lock_timer_reg == '0) begin
            state_reg      <= ST_IDLE;
            locked_out_reg <= 1'b0;
            fail_cnt_reg   <= '0;
          end else begin
            lock_timer_reg <= lock_timer_reg - LOCK_W'(1);
          end
`else
          state_reg <= ST_IDLE;
`endif
        end

        default: begin
          state_reg        <= ST_IDLE;
          entry_active_reg <= 1'b0;
        end
      endcase
    end
  end

  assign entry_active = entry_active_reg;
  assign digit_count  = digit_count_reg;
  assign granted      = granted_reg;
  assign denied       = denied_reg;
`ifdef PINPAD_LOCKOUT_EN
  assign locked_out   = locked_out_reg;
`else
  assign locked_out   = 1'b0;
`endif

endmodule

// File: tb/tb_pinpad_entry_ctrl.sv
// Randomized and directed bench for pinpad_entry_ctrl against a queue-based reference model.
module tb_pinpad_entry_ctrl;

  localparam int PIN_LEN = 4;
  localparam int DEB     = 8;
  localparam int TRIES   = 3;
  localparam int LOCK    = 1000;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 key_valid = 1'b0;
  logic [3:0]           key_code = 4'd15;
  logic [4*PIN_LEN-1:0] pin_ref = '0;
  logic                 entry_active;
  logic [$clog2(PIN_LEN+1)-1:0] digit_count;
  logic                 granted, denied, locked_out;

  pinpad_entry_ctrl #(
    .PIN_LEN(PIN_LEN), .DEBOUNCE_CYCLES(DEB), .MAX_TRIES(TRIES), .LOCKOUT_CYCLES(LOCK)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key_valid(key_valid), .key_code(key_code),
    .pin_ref(pin_ref), .entry_active(entry_active), .digit_count(digit_count),
    .granted(granted), .denied(denied), .locked_out(locked_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: state 0=idle 1=entry 2=check 3=lockout; digits kept as a queue.
  int m_state, m_fails, m_lock_left;
  int m_digits[$];
  bit m_granted, m_denied;
  int m_run, m_last, m_rel, m_scode;
  bit m_armed, m_strobe;

  task automatic model_step();
    bit pressed, fire, old_armed, ok;
    if (!reset_n) begin
      m_state = 0; m_digits.delete(); m_fails = 0; m_lock_left = 0;
      m_granted = 0; m_denied = 0;
      m_run = 0; m_last = 15; m_rel = 0; m_armed = 1; m_strobe = 0; m_scode = 15;
      return;
    end
    m_granted = 0;
    m_denied  = 0;
    case (m_state)
      0: if (m_strobe && m_scode == 10) begin m_digits.delete(); m_state = 1; end
      1: if (m_strobe) begin
           if (m_scode <= 9) begin
             if (m_digits.size() < PIN_LEN) m_digits.push_back(m_scode);
           end else if (m_scode == 11) begin
             if (m_digits.size() > 0) void'(m_digits.pop_back());
           end else if (m_scode == 12) begin
             m_digits.delete(); m_state = 0;
           end else if (m_scode == 10) begin
             m_digits.delete();
           end else if (m_scode == 13) begin
             m_state = 2;
           end
         end
      2: begin
           ok = (m_digits.size() == PIN_LEN);
           if (ok) for (int i = 0; i < PIN_LEN; i++)
             if (m_digits[i] != int'(pin_ref[4*(PIN_LEN-1-i) +: 4])) ok = 0;
           m_state = 0;
           if (ok) begin
             m_granted = 1; m_fails = 0;
           end else begin
             m_denied = 1;
             m_fails = (m_fails + 1 > TRIES) ? TRIES : m_fails + 1;
`ifdef PINPAD_LOCKOUT_EN
             if (m_fails == TRIES) begin m_state = 3; m_lock_left = LOCK; end
`endif
           end
           m_digits.delete();
         end
      default: begin
           m_lock_left--;
           if (m_lock_left == 0) begin m_state = 0; m_fails = 0; end
         end
    endcase
    pressed = key_valid && (key_code != 4'd15);
    if (pressed) begin
      if (m_run > 0 && int'(key_code) == m_last) m_run++;
      else m_run = 1;
      m_last = int'(key_code);
    end else begin
      m_run = 0;
    end
    fire = m_armed && (m_run == DEB);
    old_armed = m_armed;
    if (!old_armed && !key_valid) m_rel++;
    else m_rel = 0;
    if (fire) m_armed = 0;
    else if (!old_armed && m_rel == DEB) m_armed = 1;
    m_strobe = fire;
    m_scode  = int'(key_code);
  endtask

  int cyc = 0, d_cyc = 0, g_cyc = 0;
  int g_cnt = 0, d_cnt = 0, lock_cycles = 0, rises = 0, rises_deny = 0;
  bit prev_locked = 0;

  task automatic clear_counts();
    g_cnt = 0; d_cnt = 0; lock_cycles = 0; rises = 0; rises_deny = 0;
  endtask

  task automatic tick(input logic v, input logic [3:0] c);
    key_valid = v;
    key_code  = c;
    if (m_strobe && m_scode == 13) d_cyc = cyc;
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    check("entry_active", 32'(entry_active), 32'(m_state == 1));
    check("digit_count", 32'(digit_count), 32'(m_digits.size()));
    check("granted", 32'(granted), 32'(m_granted));
    check("denied", 32'(denied), 32'(m_denied));
    check("locked_out", 32'(locked_out), 32'(m_state == 3));
    if (granted === 1'b1) begin g_cnt++; g_cyc = cyc; end
    if (denied === 1'b1) d_cnt++;
    if (locked_out === 1'b1) lock_cycles++;
    if (locked_out === 1'b1 && !prev_locked) begin
      rises++;
      if (denied === 1'b1) rises_deny++;
    end
    prev_locked = (locked_out === 1'b1);
  endtask

  task automatic press(input int k, input int hold, input int rel);
    $display("key %0d hold=%0d release=%0d cycle=%0d", k, hold, rel, cyc);
    for (int i = 0; i < hold; i++) tick(1'b1, 4'(k));
    for (int i = 0; i < rel; i++) tick(1'b0, 4'd15);
  endtask

  task automatic key(input int k);
    press(k, DEB + 2, DEB + 1);
  endtask

  task automatic rand_press(input int k);
    int hold, rel, g;
    hold = $urandom_range(DEB - 3, 2 * DEB);
    rel  = $urandom_range(DEB - 3, 2 * DEB);
    if ($urandom_range(0, 5) == 0) begin
      g = $urandom_range(1, hold - 1);
      $display("key %0d hold=%0d glitch@%0d release=%0d cycle=%0d", k, hold, g, rel, cyc);
      for (int i = 0; i < hold; i++) tick(1'b1, (i == g) ? 4'($urandom_range(0, 15)) : 4'(k));
      for (int i = 0; i < rel; i++) tick(1'b0, 4'd15);
    end else begin
      press(k, hold, rel);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    logic [4*PIN_LEN-1:0] p;
    for (int i = 0; i < 3; i++) tick(1'b0, 4'd15);
    reset_n = 1'b1;
    check("rst_entry", 32'(entry_active), 0);
    check("rst_count", 32'(digit_count), 0);
    check("rst_granted", 32'(granted), 0);
    check("rst_denied", 32'(denied), 0);
    check("rst_locked", 32'(locked_out), 0);

    pin_ref = 16'h1234;
    clear_counts();
    key(10); key(1); key(2); key(3); key(4); key(13);
    check("seq1_grant", 32'(g_cnt), 1);
    check("seq1_deny", 32'(d_cnt), 0);
    check("seq1_count", 32'(digit_count), 0);
    check("seq1_latency", 32'(g_cyc - d_cyc), 2);

    key(10);
    press(5, 3 * DEB, DEB - 3);
    check("hold_one_digit", 32'(digit_count), 1);
    press(5, DEB + 2, DEB + 1);
    check("short_release", 32'(digit_count), 1);
    key(12);
    check("cancel_idle", 32'(entry_active), 0);

    clear_counts();
    key(10); key(1); key(2); key(9); key(11); key(3); key(4); key(13);
    check("backspace_grant", 32'(g_cnt), 1);

    key(10);
    for (int i = 1; i <= 6; i++) key(i);
    check("overflow_count", 32'(digit_count), PIN_LEN);
    key(12);

    clear_counts();
    key(10); key(1); key(2); key(13);
    check("short_deny", 32'(d_cnt), 1);
    check("short_no_grant", 32'(g_cnt), 0);

    clear_counts();
    key(10); key(12);
    check("ac_no_pulse", 32'(g_cnt + d_cnt), 0);
    check("ac_idle", 32'(entry_active), 0);

    key(10); key(1); key(2); key(3); key(4); key(13);
    clear_counts();
    for (int t = 0; t < 3; t++) begin key(10); key(9); key(9); key(13); end
    check("three_denies", 32'(d_cnt), 3);
`ifdef PINPAD_LOCKOUT_EN
    check("lock_rise", 32'(rises), 1);
    check("lock_rise_with_deny", 32'(rises_deny), 1);
    check("lock_active", 32'(locked_out), 1);
    key(10);
    check("lock_ignores_key", 32'(entry_active), 0);
    for (int i = 0; i < LOCK + 100 && locked_out === 1'b1; i++) tick(1'b0, 4'd15);
    check("lock_release", 32'(locked_out), 0);
    check("lock_length", 32'(lock_cycles), LOCK);
`else
    check("no_lockout", 32'(lock_cycles), 0);
`endif
    key(10);
    check("after_fail_accept", 32'(entry_active), 1);
    key(12);

    key(10); key(1); key(2); key(3);
    check("pre_reset_count", 32'(digit_count), 3);
    reset_n = 1'b0;
    tick(1'b0, 4'd15);
    check("midrst_entry", 32'(entry_active), 0);
    check("midrst_count", 32'(digit_count), 0);
    check("midrst_pulses", 32'(granted | denied | locked_out), 0);
    reset_n = 1'b1;

    for (int r = 0; r < 60; r++) begin
      case ($urandom_range(0, 3))
        0: begin
             rand_press(10);
             for (int i = 0; i < PIN_LEN; i++) begin
               rand_press(int'(pin_ref[4*(PIN_LEN-1-i) +: 4]));
               if ($urandom_range(0, 7) == 0) begin rand_press(7); rand_press(11); end
             end
             rand_press(13);
           end
        1: begin
             rand_press(10);
             nd = $urandom_range(0, 6);
             for (int i = 0; i < nd; i++) rand_press($urandom_range(0, 9));
             rand_press(13);
           end
        2: for (int i = 0; i < 6; i++) rand_press($urandom_range(0, 15));
        default: begin
             p = '0;
             for (int i = 0; i < PIN_LEN; i++) p[4*i +: 4] = 4'($urandom_range(0, 9));
             pin_ref = p;
             if ($urandom_range(0, 3) == 0) begin
               reset_n = 1'b0;
               tick(1'b0, 4'd15);
               reset_n = 1'b1;
             end
             tick(1'b0, 4'd15);
           end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
